// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath and pipeline_ctrl.
//   Hazard inputs : idRs, idRt, exRt, exMemRead, idDivStart, branchTaken
//   Control out   : pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush, busy
//   Debug out     : stallCount, flushCount (CNT_W bits, saturating)
// The master modport is the datapath side; the slave modport is the controller.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       idRs;
  logic [4:0]       idRt;
  logic [4:0]       exRt;
  logic             exMemRead;
  logic             idDivStart;
  logic             branchTaken;
  logic             pcWrite;
  logic             ifidWrite;
  logic             idexBubble;
  logic             ifidFlush;
  logic             idexFlush;
  logic             busy;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output idRs, idRt, exRt, exMemRead, idDivStart, branchTaken,
    input  pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush, busy,
    input  stallCount, flushCount
  );

  modport slave (
    input  idRs, idRt, exRt, exMemRead, idDivStart, branchTaken,
    output pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush, busy,
    output stallCount, flushCount
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the IF/ID and ID/EX pipeline buffers.
// Detects load-use hazards, taken-branch flushes and multi-cycle divide stalls,
// and keeps saturating stall/flush event counters for debug.
// Ports:
//   clk   - pipeline clock, state updates on posedge
//   rst_n - synchronous active-low reset
//   bus   - pipeline_ctrl_if.slave: hazard inputs, control outputs, counters
// Control outputs are combinational from state and current inputs so they
// settle well before the buffers capture on the falling edge.
module pipeline_ctrl #(
  parameter int unsigned DIV_CYCLES = 8,  // total stall cycles per divide, 2..255
  parameter int unsigned CNT_W      = 16
) (
  input logic            clk,
  input logic            rst_n,
  pipeline_ctrl_if.slave bus
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMulti   = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic load_use;
  logic stall;
  logic flush;
  logic busy;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = bus.exMemRead && (bus.exRt != 5'd0) &&
                    ((bus.exRt == bus.idRs) || (bus.exRt == bus.idRt));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    busy    = 1'b0;
    if (!rst_n) begin
      state_d = StRun;
      cnt_d   = 8'd0;
    end else if (bus.branchTaken) begin
      // Anything held in ID is wrong-path, including a pending divide.
      flush   = 1'b1;
      state_d = StRun;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        StRun: begin
          if (load_use) begin
            // One bubble suffices: the load leaves EX next cycle.
            stall = 1'b1;
          end else if (bus.idDivStart) begin
            stall   = 1'b1;
            busy    = 1'b1;
            cnt_d   = 8'(DIV_CYCLES - 2);
            state_d = StMulti;
          end
        end
        StMulti: begin
          stall = 1'b1;
          busy  = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StRelease: begin
          // The divide still sits in ID with idDivStart high; let it go.
          state_d = StRun;
        end
        default: begin
          state_d = StRun;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 8'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pcWrite    = !stall;
  assign bus.ifidWrite  = !stall;
  assign bus.idexBubble = stall;
  assign bus.ifidFlush  = flush;
  assign bus.idexFlush  = flush;
  assign bus.busy       = busy;
  assign bus.stallCount = stall_q;
  assign bus.flushCount = flush_q;

endmodule
